// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/shift/add ops plus a WIDTH-step iterative signed mul/div engine.
// Define ALU_EARLY_TERM_EN to let mul leave the iteration once the remaining multiplier bits are zero.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [2:0]       branch_type,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             illegal_op,
    output logic             branch_taken
);
    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3,
                           OP_SLL = 4'h4, OP_SRL = 4'h5, OP_ADDU = 4'h6, OP_SUBU = 4'h7,
                           OP_AND = 4'h8, OP_OR = 4'h9, OP_XOR = 4'hA, OP_NOR = 4'hB,
                           OP_CMP = 4'hC, OP_SGT = 4'hD, OP_SLT = 4'hE, OP_ILL = 4'hF;
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2:0]           br_q;
    logic                 is_div, dbz_q;
    logic [SHW-1:0]       cnt;
    logic [2*WIDTH-1:0]   acc, cand;
    logic [WIDTH-1:0]     q_r;

    function automatic logic br_eval(input logic [2:0] bt, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic eq, lt;
        eq = (x == y);
        lt = ($signed(x) < $signed(y));
        case (bt)
            3'b001:  br_eval = eq;
            3'b010:  br_eval = !eq;
            3'b011:  br_eval = !eq && !lt;
            3'b100:  br_eval = lt;
            3'b101:  br_eval = !lt;
            3'b110:  br_eval = lt || eq;
            default: br_eval = 1'b0;
        endcase
    endfunction

    // single-cycle datapath
    logic [WIDTH-1:0] sum, diff, s_res;
    logic             s_ovf;
    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        s_res = '0;
        s_ovf = 1'b0;
        case (operation)
            OP_ADD:         begin s_res = sum;  s_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]); end
            OP_SUB, OP_CMP: begin s_res = diff; s_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]); end
            OP_SLL:  s_res = b << shamt;
            OP_SRL:  s_res = b >> shamt;
            OP_ADDU: s_res = sum;
            OP_SUBU: s_res = diff;
            OP_AND:  s_res = a & b;
            OP_OR:   s_res = a | b;
            OP_XOR:  s_res = a ^ b;
            OP_NOR:  s_res = ~(a | b);
            OP_SGT:  s_res = {{(WIDTH-1){1'b0}}, $signed(a) > $signed(b)};
            OP_SLT:  s_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            default: s_res = '0;
        endcase
    end

    // One engine step. Step 0 is taken from the live operands at the start edge, so
    // ITER only needs WIDTH-1 further edges before FIN.
    logic [WIDTH-1:0]   ma, mb, src_q, nxt_q, dsub;
    logic [2*WIDTH-1:0] src_acc, src_cand, nxt_acc, nxt_cand;
    logic [WIDTH:0]     dr, dd;
    logic               src_div;
    assign ma = a[WIDTH-1] ? -a : a;
    assign mb = b[WIDTH-1] ? -b : b;

    always_comb begin
        if (state == IDLE) begin
            src_div  = (operation == OP_DIV);
            src_acc  = '0;
            src_cand = {{WIDTH{1'b0}}, (src_div ? mb : ma)};
            src_q    = src_div ? ma : mb;
        end else begin
            src_div  = is_div;
            src_acc  = acc;
            src_cand = cand;
            src_q    = q_r;
        end
        dr   = {src_acc[WIDTH-1:0], src_q[WIDTH-1]};
        dd   = {1'b0, src_cand[WIDTH-1:0]};
        dsub = dr[WIDTH-1:0] - src_cand[WIDTH-1:0];
        if (src_div) begin
            nxt_cand = src_cand;
            if (dr >= dd) begin
                nxt_acc = {{WIDTH{1'b0}}, dsub};
                nxt_q   = {src_q[WIDTH-2:0], 1'b1};
            end else begin
                nxt_acc = {{WIDTH{1'b0}}, dr[WIDTH-1:0]};
                nxt_q   = {src_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt_acc  = src_q[0] ? src_acc + src_cand : src_acc;
            nxt_cand = src_cand << 1;
            nxt_q    = src_q >> 1;
        end
    end

    logic               sgn, early_done;
    logic [2*WIDTH-1:0] mul_out;
    logic [WIDTH-1:0]   quo, remv;
    assign sgn     = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    assign mul_out = sgn ? -acc : acc;
    assign quo     = sgn ? -q_r : q_r;
    assign remv    = a_q[WIDTH-1] ? -(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
`ifdef ALU_EARLY_TERM_EN
    assign early_done = !is_div && (q_r == '0);
`else
    assign early_done = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy <= 1'b0; done <= 1'b0; result <= '0; hi <= '0;
            zero <= 1'b0; overflow <= 1'b0; div_by_zero <= 1'b0; illegal_op <= 1'b0; branch_taken <= 1'b0;
            a_q <= '0; b_q <= '0; br_q <= '0; is_div <= 1'b0; dbz_q <= 1'b0;
            cnt <= '0; acc <= '0; cand <= '0; q_r <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_q    <= a;
                    b_q    <= b;
                    br_q   <= branch_type;
                    is_div <= (operation == OP_DIV);
                    if (operation == OP_MUL || operation == OP_DIV) begin
                        busy <= 1'b1;
                        if (operation == OP_DIV && b == '0) begin
                            dbz_q <= 1'b1;
                            state <= FIN;
                        end else begin
                            dbz_q <= 1'b0;
                            acc   <= nxt_acc;
                            cand  <= nxt_cand;
                            q_r   <= nxt_q;
                            cnt   <= SHW'(1);
                            state <= ITER;
                        end
                    end else begin
                        result       <= s_res;
                        hi           <= '0;
                        zero         <= (s_res == '0);
                        overflow     <= s_ovf;
                        div_by_zero  <= 1'b0;
                        illegal_op   <= (operation == OP_ILL);
                        branch_taken <= br_eval(branch_type, a, b);
                        done         <= 1'b1;
                    end
                end
                ITER: begin
                    if (early_done) begin
                        state <= FIN;
                    end else begin
                        acc  <= nxt_acc;
                        cand <= nxt_cand;
                        q_r  <= nxt_q;
                        if (cnt == SHW'(WIDTH-1)) state <= FIN;
                        else                      cnt   <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    if (dbz_q) begin
                        result   <= '1;
                        hi       <= a_q;
                        zero     <= 1'b0;
                        overflow <= 1'b0;
                    end else if (is_div) begin
                        result   <= quo;
                        hi       <= remv;
                        zero     <= (quo == '0);
                        overflow <= (a_q == MINV) && (b_q == '1);
                    end else begin
                        result   <= mul_out[WIDTH-1:0];
                        hi       <= mul_out[2*WIDTH-1:WIDTH];
                        zero     <= (mul_out[WIDTH-1:0] == '0);
                        overflow <= 1'b0;
                    end
                    div_by_zero  <= dbz_q;
                    illegal_op   <= 1'b0;
                    branch_taken <= br_eval(br_q, a_q, b_q);
                    busy         <= 1'b0;
                    done         <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; latency counts the cycle after the start edge as 1.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  operation = '0;
    logic [2:0]  branch_type = '0;
    logic [31:0] a = '0, b = '0;
    logic [4:0]  shamt = '0;
    logic        busy, done, zero, overflow, div_by_zero, illegal_op, branch_taken;
    logic [31:0] result, hi;
    int checks = 0, errors = 0, lat;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .operation(operation), .branch_type(branch_type),
        .a(a), .b(b), .shamt(shamt), .busy(busy), .done(done), .result(result), .hi(hi),
        .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero), .illegal_op(illegal_op),
        .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

`ifdef ALU_EARLY_TERM_EN
    localparam int MUL_LAT = 4;
`else
    localparam int MUL_LAT = 33;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one op and return cycles until done (capped at 100).
    task automatic run(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [4:0] sh, input logic [2:0] bt, output int l);
        operation = op; a = ia; b = ib; shamt = sh; branch_type = bt; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        l = 1;
        while (!done && l < 100) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    initial begin
        #12;
        chk("rst_busy", busy, 0);  chk("rst_done", done, 0);  chk("rst_result", result, 0);
        chk("rst_hi", hi, 0);      chk("rst_zero", zero, 0);  chk("rst_ovf", overflow, 0);
        chk("rst_dbz", div_by_zero, 0); chk("rst_ill", illegal_op, 0); chk("rst_br", branch_taken, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // T1 add overflow
        run(4'h0, 32'h7FFFFFFF, 32'h1, 0, 3'b000, lat);
        chk("t1_lat", lat, 1); chk("t1_res", result, 32'h80000000);
        chk("t1_ovf", overflow, 1); chk("t1_zero", zero, 0); chk("t1_busy", busy, 0);
        // T2 sub with beq / bne
        run(4'h1, 32'd5, 32'd5, 0, 3'b001, lat);
        chk("t2_res", result, 0); chk("t2_zero", zero, 1); chk("t2_beq", branch_taken, 1);
        run(4'h1, 32'd5, 32'd5, 0, 3'b010, lat);
        chk("t2_bne", branch_taken, 0); chk("t2_ovf", overflow, 0);
        // unsigned add does not flag, slt/sll/srl/nor
        run(4'h6, 32'h7FFFFFFF, 32'h1, 0, 3'b000, lat);
        chk("addu_res", result, 32'h80000000); chk("addu_ovf", overflow, 0);
        run(4'hE, 32'hFFFFFFFF, 32'h1, 0, 3'b100, lat);
        chk("slt_res", result, 1); chk("slt_blt", branch_taken, 1);
        run(4'h4, 32'h0, 32'h1, 5'd31, 3'b111, lat);
        chk("sll_res", result, 32'h80000000); chk("sll_br7", branch_taken, 0);
        run(4'h5, 32'h0, 32'h80000000, 5'd4, 3'b000, lat);
        chk("srl_res", result, 32'h08000000);
        run(4'hB, 32'h0, 32'h0, 0, 3'b000, lat);
        chk("nor_res", result, 32'hFFFFFFFF); chk("nor_zero", zero, 0);
        run(4'h1, 32'h80000000, 32'h1, 0, 3'b000, lat);
        chk("sub_ovf", overflow, 1); chk("sub_res", result, 32'h7FFFFFFF);

        // back-to-back single-cycle ops
        operation = 4'h0; a = 32'd1; b = 32'd1; branch_type = 3'b000; start = 1'b1;
        @(posedge clk); #1;
        chk("b2b_res0", result, 2); chk("b2b_done0", done, 1);
        operation = 4'hA; a = 32'hF0; b = 32'hFF;
        @(posedge clk); #1;
        chk("b2b_res1", result, 32'h0F); chk("b2b_done1", done, 1);
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b_done_clr", done, 0);

        // T3 mul -2*3 with a second start during busy
        operation = 4'h2; a = 32'hFFFFFFFE; b = 32'd3; branch_type = 3'b100; start = 1'b1;
        @(posedge clk); #1;
        chk("t3_busy", busy, 1); chk("t3_nodone", done, 0);
        operation = 4'h0; a = 32'd1; b = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t3_lat", lat, MUL_LAT); chk("t3_res", result, 32'hFFFFFFFA);
        chk("t3_hi", hi, 32'hFFFFFFFF); chk("t3_ovf", overflow, 0); chk("t3_blt", branch_taken, 1);
        @(posedge clk); #1;
        chk("t3_busy_end", busy, 0); chk("t3_no2nd", done, 0); chk("t3_held", result, 32'hFFFFFFFA);
        // mul result low word zero: zero tracks result only
        run(4'h2, 32'h00010000, 32'h00010000, 0, 3'b000, lat);
        chk("mul_big_res", result, 0); chk("mul_big_hi", hi, 1); chk("mul_big_zero", zero, 1);
        run(4'h2, 32'h80000000, 32'hFFFFFFFF, 0, 3'b000, lat);
        chk("mul_min_res", result, 32'h80000000); chk("mul_min_hi", hi, 0);

        // T4 div
        run(4'h3, 32'hFFFFFFF9, 32'd2, 0, 3'b000, lat);
        chk("t4_lat", lat, 33); chk("t4_res", result, 32'hFFFFFFFD); chk("t4_hi", hi, 32'hFFFFFFFF);
        run(4'h3, 32'd7, 32'hFFFFFFFE, 0, 3'b000, lat);
        chk("div_res2", result, 32'hFFFFFFFD); chk("div_hi2", hi, 32'd1);
        run(4'h3, 32'd9, 32'd0, 0, 3'b000, lat);
        chk("dbz_lat", lat, 2); chk("dbz_res", result, 32'hFFFFFFFF);
        chk("dbz_hi", hi, 32'd9); chk("dbz_flag", div_by_zero, 1);
        // T5
        run(4'h3, 32'h80000000, 32'hFFFFFFFF, 0, 3'b000, lat);
        chk("t5_res", result, 32'h80000000); chk("t5_hi", hi, 0);
        chk("t5_ovf", overflow, 1); chk("t5_dbz", div_by_zero, 0);

        // T6 reset mid-div
        operation = 4'h3; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("t6_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0); chk("t6_done", done, 0);
        chk("t6_res", result, 0); chk("t6_hi", hi, 0); chk("t6_ovf", overflow, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_done", done, 0);
        run(4'h0, 32'd2, 32'd3, 0, 3'b000, lat);
        chk("t6_add_lat", lat, 1); chk("t6_add_res", result, 5);

        run(4'hF, 32'd4, 32'd4, 0, 3'b000, lat);
        chk("ill_lat", lat, 1); chk("ill_res", result, 0); chk("ill_flag", illegal_op, 1);
        chk("ill_zero", zero, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
